// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch / load-store) in front of the single-port memory.
// Build option MEM_ARB_RR_EN selects round-robin instead of data priority with fetch starvation guard.
module mem_arbiter #(
  parameter int width      = 64,
  parameter int depth      = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_req,
  input  logic [width-1:0] if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [width-1:0] if_rdata,
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [width-1:0] dm_addr,
  input  logic [width-1:0] dm_wdata,
  output logic             dm_gnt,
  output logic             dm_rvalid,
  output logic [width-1:0] dm_rdata,
  output logic             memoryRead,
  output logic             memoryWri,
  output logic [width-1:0] address,
  output logic [width-1:0] dataWri,
  input  logic [width-1:0] dataRead
);

  logic [3:0] starve_cnt;
`ifdef MEM_ARB_RR_EN
  logic       last_owner;  // 1 = data port owned the most recent grant
`endif

  // Only the word-index bits reach memory; upper address bits are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{if_addr[width-1:depth], dm_addr[width-1:depth]};

  // Stage p0: combinational grant and memory command
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (rst_n) begin
      if (if_req && dm_req) begin
`ifdef MEM_ARB_RR_EN
        if (last_owner) if_gnt = 1'b1;
        else            dm_gnt = 1'b1;
`else
        if (starve_cnt == 4'(STARVE_MAX)) if_gnt = 1'b1;
        else                              dm_gnt = 1'b1;
`endif
      end else begin
        if_gnt = if_req;
        dm_gnt = dm_req;
      end
    end
  end

  always_comb begin
    memoryRead = 1'b0;
    memoryWri  = 1'b0;
    address    = '0;
    dataWri    = '0;
    if (if_gnt) begin
      memoryRead          = 1'b1;
      address[depth-1:0]  = if_addr[depth-1:0];
    end else if (dm_gnt) begin
      memoryRead          = ~dm_we;
      memoryWri           = dm_we;
      address[depth-1:0]  = dm_addr[depth-1:0];
      if (dm_we) dataWri  = dm_wdata;
    end
  end

  // Stage p1: registered read response and arbitration state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_rvalid  <= 1'b0;
      dm_rvalid  <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      starve_cnt <= '0;
`ifdef MEM_ARB_RR_EN
      last_owner <= 1'b1;
`endif
    end else begin
      if_rvalid <= if_gnt;
      dm_rvalid <= dm_gnt && !dm_we;
      if (if_gnt)           if_rdata <= dataRead;
      if (dm_gnt && !dm_we) dm_rdata <= dataRead;
`ifdef MEM_ARB_RR_EN
      starve_cnt <= '0;
      if (if_gnt)      last_owner <= 1'b0;
      else if (dm_gnt) last_owner <= 1'b1;
`else
      if (!if_req || if_gnt)
        starve_cnt <= '0;
      else if (starve_cnt != 4'(STARVE_MAX))
        starve_cnt <= starve_cnt + 4'd1;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory model behind the arbiter.
module tb_mem_arbiter;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         if_req, dm_req, dm_we;
  logic [W-1:0] if_addr, dm_addr, dm_wdata;
  logic         if_gnt, if_rvalid, dm_gnt, dm_rvalid;
  logic [W-1:0] if_rdata, dm_rdata;
  logic         memoryRead, memoryWri;
  logic [W-1:0] address, dataWri, dataRead;

  logic [W-1:0] mem [0:255];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign dataRead = mem[address[7:0]];
  always @(posedge clk) if (memoryWri) mem[address[7:0]] <= dataWri;

  mem_arbiter #(.width(64), .depth(8), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .memoryRead(memoryRead), .memoryWri(memoryWri),
    .address(address), .dataWri(dataWri), .dataRead(dataRead)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] pat;
    logic       prev_f;
    for (int i = 0; i < 256; i++) mem[i] = 64'(i) * 64'h0101;
    mem[8'h10] = 64'hDEADBEEF;
    mem[8'h05] = 64'hA5A5;

    // Reset with both requesters active, data side attempting a write
    rst_n = 1'b0; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b1;
    if_addr = 64'h10; dm_addr = 64'h30; dm_wdata = 64'hBAD;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_if_gnt", {63'd0, if_gnt}, 64'd0);
      check("rst_dm_gnt", {63'd0, dm_gnt}, 64'd0);
      check("rst_memWri", {63'd0, memoryWri}, 64'd0);
      check("rst_memRead", {63'd0, memoryRead}, 64'd0);
      check("rst_if_rvalid", {63'd0, if_rvalid}, 64'd0);
      check("rst_dm_rvalid", {63'd0, dm_rvalid}, 64'd0);
      check("rst_if_rdata", if_rdata, 64'd0);
      check("rst_dm_rdata", dm_rdata, 64'd0);
    end
    rst_n = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    tick();
    check("no_write_in_reset", mem[8'h30], 64'h3030);

    // Single fetch
    if_req = 1'b1; if_addr = 64'h10;
    #1;
    check("sf_if_gnt", {63'd0, if_gnt}, 64'd1);
    check("sf_dm_gnt", {63'd0, dm_gnt}, 64'd0);
    check("sf_memRead", {63'd0, memoryRead}, 64'd1);
    check("sf_address", address, 64'h10);
    tick();
    check("sf_if_rvalid", {63'd0, if_rvalid}, 64'd1);
    check("sf_if_rdata", if_rdata, 64'hDEADBEEF);
    check("sf_dm_rvalid", {63'd0, dm_rvalid}, 64'd0);
    if_req = 1'b0;
    tick();
    check("sf_if_rvalid_drop", {63'd0, if_rvalid}, 64'd0);

    // Data write then read of the same word
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h20; dm_wdata = 64'h1234;
    #1;
    check("wr_dm_gnt", {63'd0, dm_gnt}, 64'd1);
    check("wr_memWri", {63'd0, memoryWri}, 64'd1);
    check("wr_memRead", {63'd0, memoryRead}, 64'd0);
    check("wr_dataWri", dataWri, 64'h1234);
    check("wr_address", address, 64'h20);
    tick();
    check("wr_no_rvalid", {63'd0, dm_rvalid}, 64'd0);
    dm_we = 1'b0;
    #1;
    check("rd_memRead", {63'd0, memoryRead}, 64'd1);
    check("rd_dataWri", dataWri, 64'd0);
    tick();
    check("rd_dm_rvalid", {63'd0, dm_rvalid}, 64'd1);
    check("rd_dm_rdata", dm_rdata, 64'h1234);
    check("rd_if_rdata_hold", if_rdata, 64'hDEADBEEF);

    // Upper address bits are masked off
    dm_addr = 64'h1_0000_0005;
    #1;
    check("mask_address", address, 64'h05);
    tick();
    check("mask_rdata", dm_rdata, 64'hA5A5);
    dm_req = 1'b0;
    #1;
    check("idle_memRead", {63'd0, memoryRead}, 64'd0);
    check("idle_memWri", {63'd0, memoryWri}, 64'd0);
    check("idle_address", address, 64'd0);
    check("idle_dataWri", dataWri, 64'd0);
    tick();
    check("idle_dm_rvalid", {63'd0, dm_rvalid}, 64'd0);

    // Reset arriving in the grant cycle drops the read
    if_req = 1'b1; if_addr = 64'h10;
    #1;
    check("rm_if_gnt", {63'd0, if_gnt}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("rm_gnt_in_reset", {63'd0, if_gnt}, 64'd0);
    tick();
    check("rm_no_rvalid", {63'd0, if_rvalid}, 64'd0);
    check("rm_rdata_cleared", if_rdata, 64'd0);
    if_req = 1'b0;
    tick();
    rst_n = 1'b1;

    // Continuous contention from a clean reset
    if_req = 1'b1; if_addr = 64'h10;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h20;
`ifdef MEM_ARB_RR_EN
    pat = 10'b0101010101;
`else
    pat = 10'b1000010000;
`endif
    prev_f = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("cont_if_gnt_%0d", i), {63'd0, if_gnt}, {63'd0, pat[i]});
      check($sformatf("cont_dm_gnt_%0d", i), {63'd0, dm_gnt}, {63'd0, ~pat[i]});
      check($sformatf("cont_addr_%0d", i), address, pat[i] ? 64'h10 : 64'h20);
      tick();
      check($sformatf("cont_if_rvalid_%0d", i), {63'd0, if_rvalid}, {63'd0, pat[i]});
      check($sformatf("cont_dm_rvalid_%0d", i), {63'd0, dm_rvalid}, {63'd0, ~pat[i]});
      if (pat[i]) check($sformatf("cont_if_rdata_%0d", i), if_rdata, 64'hDEADBEEF);
      else        check($sformatf("cont_dm_rdata_%0d", i), dm_rdata, 64'h1234);
      prev_f = pat[i];
    end
    check("cont_last_fetch", {63'd0, prev_f}, {63'd0, pat[9]});
    if_req = 1'b0; dm_req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-port `memory` block between the pipeline's instruction-fetch port and its load/store port. It sits between the fetch and memory stages and the `memory` instance. It drives `memoryRead`, `memoryWri`, `address` and `dataWri`, and returns registered read data to each requester one cycle after its grant. The default policy gives the data port fixed priority, with a starvation counter that guarantees fetch forward progress.

## Interface
- `width`, 64, data and address width; matches `memory`.
- `depth`, 8, log2 of memory words; matches `memory`.
- `STARVE_MAX`, 4, number of consecutive denied fetch-request cycles before fetch is forced to win; legal range 1..15.

Ports:
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `if_req` in 1: fetch read request; held until granted.
- `if_addr` in width: fetch word address; stable while `if_req` is high.
- `if_gnt` out 1: fetch granted this cycle (combinational).
- `if_rvalid` out 1: `if_rdata` is valid (registered).
- `if_rdata` out width: fetch read data.
- `dm_req` in 1: data request; held until granted.
- `dm_we` in 1: 1 = write, 0 = read; qualified by `dm_req`.
- `dm_addr` in width: data word address.
- `dm_wdata` in width: write data.
- `dm_gnt` out 1: data port granted this cycle (combinational).
- `dm_rvalid` out 1: `dm_rdata` is valid (registered; reads only).
- `dm_rdata` out width: data read data.
- `memoryRead` out 1: to `memory`.
- `memoryWri` out 1: to `memory`.
- `address` out width: to `memory`; bits [width-1:depth] are forced to 0.
- `dataWri` out width: to `memory`.
- `dataRead` in width: from `memory` (combinational read).

## Operation
- At most one grant per cycle. `if_gnt` and `dm_gnt` are never both 1.
- Default policy when both ports request:
  - `dm_req` wins.
  - Exception: if `starve_cnt` == `STARVE_MAX`, `if_req` wins.
- When only one port requests, that port is granted immediately.
- `starve_cnt` is a 4-bit counter:
  - Increments when `if_req` is high and `if_gnt` is low.
  - Clears when `if_gnt` is high or `if_req` is low.
  - Saturates at `STARVE_MAX`.
- Grant to fetch: `memoryRead`=1, `memoryWri`=0, `address`=masked `if_addr`, `dataWri`=0.
- Grant to data with `dm_we`=0: `memoryRead`=1, `memoryWri`=0, `address`=masked `dm_addr`, `dataWri`=0.
- Grant to data with `dm_we`=1: `memoryRead`=0, `memoryWri`=1, `address`=masked `dm_addr`, `dataWri`=`dm_wdata`. The write commits at the same rising edge. No `dm_rvalid` is produced.
- No grant: all memory-side outputs are 0.
- Response register: at each rising edge, for a granted read, `dataRead` is captured into the granted port's `*_rdata` and that port's `*_rvalid` is set for exactly one cycle. The other port's `*_rdata` holds its last value.
- Requesters may issue back-to-back requests. One request per grant cycle, so full throughput is one access per clock.

## Timing
- Grant latency: 0 cycles; combinational from `*_req`.
- Read data latency: `*_rvalid` asserts 1 cycle after the grant cycle.
- Write latency: committed at the end of the grant cycle.
- Worst-case fetch wait under continuous `dm_req`: `STARVE_MAX` denied cycles, then granted on the next cycle.
- Reset (`rst_n`=0 at a rising edge) sets:
  - `if_rvalid`, `dm_rvalid` to 0;
  - `if_rdata`, `dm_rdata` to 0;
  - `starve_cnt` to 0.
- While `rst_n`=0:
  - Both grants are 0, and all memory-side outputs are 0; no write reaches memory.
  - A read granted in the cycle before reset is dropped, so no `rvalid` follows.
- Request deasserted without a grant: the request is withdrawn and not an error.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin policy replaces priority-plus-starvation.
  - A 1-bit `last_owner` register resets to 1 (data), so the first contention goes to fetch.
  - On contention, the port that was not `last_owner` wins; `last_owner` updates on every grant.
  - `starve_cnt` and `STARVE_MAX` are unused and remain 0.
- `MEM_ARB_RR_EN` undefined: the fixed data priority with starvation counter described above.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with both requests high. Required: both grants 0, `memoryWri`=0, both `rvalid`=0, both `rdata`=0.
- Single fetch:
  - Stimulus: `if_req`=1, `if_addr`=0x10, memory word 0x10 preloaded to 0xDEADBEEF.
  - Required: `if_gnt`=1 in the same cycle; `if_rvalid`=1 with `if_rdata`=0xDEADBEEF one cycle later.
- Write then read:
  - Stimulus: data write to 0x20 with 0x1234, then data read of 0x20 on the next cycle.
  - Required: `dm_rvalid`=1 and `dm_rdata`=0x1234 two cycles after the write grant; no `dm_rvalid` for the write.
- Starvation (macro off, `STARVE_MAX`=4):
  - Stimulus: both ports request continuously.
  - Required: `dm_gnt` for 4 cycles, `if_gnt` on cycle 5, then `dm_gnt` for 4 more cycles.
- Address mask: `dm_addr`=0x1_0000_0005 read. Required: `address`=0x05.
- Round-robin (macro on): both ports request continuously. Required: grants alternate fetch, data, fetch, data starting with fetch after reset; reset mid-read suppresses the pending `rvalid`.
